mac_seq_ctrl: RTL and testbench

Sequencer for one MAC DSP element of the systolic array. It accepts a job of `len` multiply-accumulate terms and drives the DSP enables (`aen`, `ben`, `men`, `sen`, `sreset`) in lock-step with an operand stream from the feeder. It tracks in-flight terms through the DSP's three register stages, tolerates stream bubbles, and fires `sreset` exactly when the last term reaches the accumulate stage. That `sreset` captures the 16-bit saturated result and clears the accumulator. One instance sits beside each DSP element; the array control FSM issues jobs through it.

---
 rtl/mac_seq_ctrl_if.sv | 37 +++
 rtl/mac_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Job/operand handshake and DSP enable bundle between array control and one mac_seq_ctrl.
// The timeout qualifier exists only when MAC_SEQ_TIMEOUT_EN is defined.
interface mac_seq_ctrl_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic             start_ready;
    logic [LEN_W-1:0] len;
    logic             op_valid;
    logic             op_ready;
    logic             aen;
    logic             ben;
    logic             men;
    logic             sen;
    logic             sreset;
    logic             busy;
    logic             done;
`ifdef MAC_SEQ_TIMEOUT_EN
    logic             timeout;
`endif

    modport master (
        output start, len, op_valid,
        input  start_ready, op_ready, aen, ben, men, sen, sreset, busy, done
`ifdef MAC_SEQ_TIMEOUT_EN
        , timeout
`endif
    );

    modport slave (
        input  start, len, op_valid,
        output start_ready, op_ready, aen, ben, men, sen, sreset, busy, done
`ifdef MAC_SEQ_TIMEOUT_EN
        , timeout
`endif
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer driving the enables of one MAC DSP element through its three register stages.
// Optional stall timeout / abort path enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_seq_ctrl #(
    parameter int unsigned LEN_W = 8
`ifdef MAC_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_seq_ctrl_if.slave  bus
);

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
`ifdef MAC_SEQ_TIMEOUT_EN
        ,
        ABORT = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             v2_q, v2_d;
    logic             l2_q, l2_d;
    logic             sen_q, sen_d;
    logic             sreset_q, sreset_d;
    logic             done_q, done_d;
    logic             start_ready_q, start_ready_d;
    logic             busy_q, busy_d;
    logic             issue;
`ifdef MAC_SEQ_TIMEOUT_EN
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    // A term is issued whenever the feeder presents operands while running.
    assign issue = bus.op_valid & (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        v2_d        = issue;
        l2_d        = issue & (remaining_q == LEN_W'(1));
        sen_d       = v2_q & ~l2_q;
        sreset_d    = v2_q & l2_q;
        done_d      = 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
        stall_d     = '0;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        remaining_d = bus.len;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
`ifdef MAC_SEQ_TIMEOUT_EN
                else begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ABORT;
                    end
                end
`endif
            end
            DRAIN: begin
                if (sreset_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef MAC_SEQ_TIMEOUT_EN
            // Let in-flight terms settle, then flush the accumulator once.
            ABORT: begin
                if (sreset_q) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (!v2_q && !sen_q) begin
                    sreset_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            v2_q          <= 1'b0;
            l2_q          <= 1'b0;
            sen_q         <= 1'b0;
            sreset_q      <= 1'b0;
            done_q        <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            stall_q       <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            v2_q          <= v2_d;
            l2_q          <= l2_d;
            sen_q         <= sen_d;
            sreset_q      <= sreset_d;
            done_q        <= done_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
`ifdef MAC_SEQ_TIMEOUT_EN
            stall_q       <= stall_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign bus.op_ready    = (state_q == RUN);
    assign bus.aen         = issue;
    assign bus.ben         = issue;
    assign bus.men         = v2_q;
    assign bus.sen         = sen_q;
    assign bus.sreset      = sreset_q;
    assign bus.done        = done_q;
    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
`ifdef MAC_SEQ_TIMEOUT_EN
    assign bus.timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a small behavioural DSP element driven by its enables.
// Timeout scenarios are included when MAC_SEQ_TIMEOUT_EN is defined.
module tb_mac_seq_ctrl;
    localparam int unsigned LEN_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

`ifdef MAC_SEQ_TIMEOUT_EN
    mac_seq_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // DSP element model: operand, product, accumulator stages; sreset folds the product in and saturates.
    logic signed [15:0] a_val, b_val;
    logic signed [15:0] a_r, b_r, s_out;
    logic signed [31:0] p_r;
    logic signed [47:0] acc;
    logic               sat;
    wire  signed [47:0] sum_w = acc + 48'(p_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; p_r <= '0; acc <= '0; s_out <= '0; sat <= 1'b0;
        end else begin
            if (bus.aen) a_r <= a_val;
            if (bus.ben) b_r <= b_val;
            if (bus.men) p_r <= a_r * b_r;
            if (bus.sen) acc <= acc + 48'(p_r);
            if (bus.sreset) begin
                acc <= '0;
                if (sum_w > 48'sd32767) begin
                    s_out <= 16'sh7FFF; sat <= 1'b1;
                end else if (sum_w < -48'sd32768) begin
                    s_out <= 16'sh8000; sat <= 1'b1;
                end else begin
                    s_out <= sum_w[15:0]; sat <= 1'b0;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic signed [15:0] op_a [4];
    logic signed [15:0] op_b [4];
    logic [31:0] r_men, r_sen;
    int          r_sreset_cyc, r_sreset_cnt, r_done_cyc;
    logic        r_timeout, r_ready_at_done;

    // Issue one job; records enable traces relative to the acceptance cycle S.
    task automatic run_job(input int n, input int gap_at, input int gap_n, input bit hold_start);
        int issued = 0;
        int gap_left = gap_n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        @(posedge clk);
        r_men = '0; r_sen = '0; r_sreset_cyc = -1; r_sreset_cnt = 0; r_done_cyc = -1;
        r_timeout = 1'b0; r_ready_at_done = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (!hold_start) bus.start = 1'b0;
            r_men[c] = bus.men;
            r_sen[c] = bus.sen;
            if (bus.sreset) begin
                r_sreset_cyc = c;
                r_sreset_cnt++;
            end
            if (bus.done) begin
                r_done_cyc      = c;
                r_ready_at_done = bus.start_ready;
`ifdef MAC_SEQ_TIMEOUT_EN
                r_timeout       = bus.timeout;
`endif
                break;
            end
            bus.op_valid = 1'b0;
            if (bus.op_ready && issued < n) begin
                if (issued == gap_at && gap_left > 0) begin
                    gap_left--;
                end else begin
                    bus.op_valid = 1'b1;
                    a_val = op_a[issued];
                    b_val = op_b[issued];
                    issued++;
                end
            end
        end
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.op_valid = 1'b0;
        a_val = '0; b_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst start_ready", 32'(bus.start_ready), 32'd1);
        check("rst busy",        32'(bus.busy),        32'd0);
        check("rst outs", {27'd0, bus.men, bus.sen, bus.sreset, bus.done, bus.op_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // len=4, no bubbles: sum of products 2+12+30+56.
        op_a = '{16'sd1, 16'sd3, 16'sd5, 16'sd7};
        op_b = '{16'sd2, 16'sd4, 16'sd6, 16'sd8};
        run_job(4, -1, 0, 1'b0);
        check("j4 men",    r_men,        32'h3C);
        check("j4 sen",    r_sen,        32'h38);
        check("j4 sreset", 32'(r_sreset_cyc), 32'd6);
        check("j4 done",   32'(r_done_cyc),   32'd7);
        check("j4 ready",  32'(r_ready_at_done), 32'd1);
        check("j4 s_out",  {16'd0, s_out}, 32'h0064);
        check("j4 sat",    32'(sat), 32'd0);
`ifdef MAC_SEQ_TIMEOUT_EN
        check("j4 timeout", 32'(r_timeout), 32'd0);
`endif

        // len=1: single term goes straight to sreset.
        op_a[0] = -16'sd3; op_b[0] = 16'sd5;
        run_job(1, -1, 0, 1'b0);
        check("j1 sen",    r_sen,        32'h0);
        check("j1 men",    r_men,        32'h4);
        check("j1 sreset", 32'(r_sreset_cyc), 32'd3);
        check("j1 done",   32'(r_done_cyc),   32'd4);
        check("j1 s_out",  {16'd0, s_out}, 32'h0000_FFF1);

        // len=3 with a 2-cycle bubble after the first term: 6-20+42.
        op_a = '{16'sd2, 16'sd4, 16'sd6, 16'sd0};
        op_b = '{16'sd3, -16'sd5, 16'sd7, 16'sd0};
        run_job(3, 1, 2, 1'b0);
        check("gap men",    r_men,        32'h64);
        check("gap sen",    r_sen,        32'h48);
        check("gap sreset", 32'(r_sreset_cyc), 32'd7);
        check("gap done",   32'(r_done_cyc),   32'd8);
        check("gap s_out",  {16'd0, s_out}, 32'h001C);

        // Saturation: 2 * 32767^2 clamps to 32767.
        op_a = '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0};
        op_b = '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0};
        run_job(2, -1, 0, 1'b0);
        check("sat done",  32'(r_done_cyc), 32'd5);
        check("sat s_out", {16'd0, s_out}, 32'h7FFF);
        check("sat flag",  32'(sat), 32'd1);

        // len=0: immediate done, no enables, s_out untouched.
        run_job(0, -1, 0, 1'b0);
        check("z done",   32'(r_done_cyc), 32'd1);
        check("z men",    r_men, 32'h0);
        check("z sreset", 32'(r_sreset_cnt), 32'd0);
        check("z s_out",  {16'd0, s_out}, 32'h7FFF);

        // start held throughout the job is ignored until done.
        op_a = '{16'sd1, 16'sd2, 16'sd0, 16'sd0};
        op_b = '{16'sd1, 16'sd2, 16'sd0, 16'sd0};
        run_job(2, -1, 0, 1'b1);
        check("hold done",   32'(r_done_cyc),   32'd5);
        check("hold sreset", 32'(r_sreset_cnt), 32'd1);
        check("hold s_out",  {16'd0, s_out}, 32'h0005);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1'b1; bus.len = LEN_W'(4);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_valid = 1'b1; a_val = 16'sd9; b_val = 16'sd9;
        @(negedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid rst start_ready", 32'(bus.start_ready), 32'd1);
        check("mid rst busy",        32'(bus.busy),        32'd0);
        check("mid rst outs", {26'd0, bus.aen, bus.men, bus.sen, bus.sreset, bus.done, bus.op_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_a[0] = 16'sd3; op_b[0] = 16'sd4;
        run_job(1, -1, 0, 1'b0);
        check("post rst done",  32'(r_done_cyc), 32'd4);
        check("post rst s_out", {16'd0, s_out}, 32'h000C);

`ifdef MAC_SEQ_TIMEOUT_EN
        // Stream stops after 2 of 4 terms: abort after 8 stall cycles.
        op_a = '{16'sd1, 16'sd3, 16'sd5, 16'sd7};
        op_b = '{16'sd2, 16'sd4, 16'sd6, 16'sd8};
        run_job(4, 2, 100, 1'b0);
        check("to sreset cnt", 32'(r_sreset_cnt), 32'd1);
        check("to sreset",     32'(r_sreset_cyc), 32'd12);
        check("to done",       32'(r_done_cyc),   32'd13);
        check("to timeout",    32'(r_timeout),    32'd1);
        op_a[0] = 16'sd3; op_b[0] = 16'sd4;
        run_job(1, -1, 0, 1'b0);
        check("to next s_out",   {16'd0, s_out}, 32'h000C);
        check("to next timeout", 32'(r_timeout), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
